demux_8bit_deser: RTL
=====================

# demux_8bit_deser

Serial-in, 8-bit parallel-out deserializer built around a 1-to-8 demultiplexer: each accepted input bit is steered to the register position selected by a 3-bit sequence counter. It is the inverse of the 8-to-1 select path, turning the calculator's serial operand/result stream back into a parallel byte. A one-deep output holding register with a valid/ready handshake lets the downstream stage stall without losing a frame.

## Interface
- `LSB_FIRST`, default 1: 1 = first bit of a frame lands in `q[0]`; 0 = first bit lands in `q[7]`.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `g_n`  in  1  active-low enable; high blocks input acceptance.
- `clr`  in  1  synchronous abort of the partial frame.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept a bit.
- `q`  out  8  assembled byte.
- `q_valid`  out  1  `q` holds an unconsumed frame.
- `q_ready`  in  1  downstream consumes `q` when `q_valid` is high.
- `bit_cnt`  out  3  current demux select, 0..7.
- `parity_err`  out  1  parity flag, qualified by `q_valid`.

## Operation
- **Accept:** a bit is accepted when `din_valid & din_ready`.
- **`din_ready`:** equals `~g_n & (state != WAIT)`.
- **States:**
  - COLLECT: each accept writes `din` into shadow bit `sh[idx]`. `idx = bit_cnt` when `LSB_FIRST=1`, else `7-bit_cnt`. `bit_cnt` then increments.
  - PARITY: present only with the configuration macro.
  - WAIT: a frame is complete but the output register is full.
- **Frame completion:** the accept with `bit_cnt==7` wraps `bit_cnt` to 0 and completes the frame, or enters PARITY when the macro is defined.
- **Completion with the output slot free** (`~q_valid | q_ready`): load `q` with `sh` plus the final bit, set `q_valid`, stay in COLLECT.
- **Completion with the output slot full:** store the final bit in `sh` and enter WAIT. In WAIT, when `q_ready` is seen, load `q` from `sh`, keep `q_valid` high, and return to COLLECT.
- **Clearing `q_valid`:** on `q_valid & q_ready` with no load in the same cycle.
- **`g_n` high mid-frame:** `bit_cnt` and `sh` hold, and the frame resumes when `g_n` falls. Consumption of `q` is unaffected.
- **`clr`:** `bit_cnt` goes to 0, `sh` goes to 0, state goes to COLLECT, and any frame waiting in WAIT is discarded. `q` and `q_valid` are untouched. `clr` has priority over an accept in the same cycle.
- **Reset:**
  - `q` = 0, `q_valid` = 0, `parity_err` = 0.
  - `bit_cnt` = 0, `sh` = 0, state = COLLECT.
  - `din_ready` = 1 if `g_n` is low.
  - `rst` overrides `clr` and all handshakes.

## Timing
- **Latency:** the last bit accepted on edge N gives `q_valid` high after edge N. With parity, the latency is measured from the parity-bit accept.
- **Throughput:** one bit per cycle sustained. Back-to-back frames incur no bubble when `q_ready` stays high.
- **Simultaneous frame completion and `q_ready`:** the old frame is consumed and the new one loaded in the same edge, and `q_valid` stays 1.
- **WAIT:** `din_ready` is 0 from the cycle after entry until the cycle after the `q_ready` release.
- **`bit_cnt` output:** registered; shows the index of the next bit to be written.

## Configuration
- **Macro:** `DEMUX_DESER_PARITY_EN`.
- **Defined:**
  - After bit 7 the FSM enters PARITY, and the next accepted bit is the parity bit.
  - Even parity is checked over 8 data bits plus the parity bit. `parity_err` is registered with `q` (1 = odd count).
  - `clr` in PARITY aborts the frame.
- **Undefined:** no PARITY state, the frame is 8 bits, and `parity_err` is tied to 0. The port list is identical in both builds.

## Structure
- **Package `demux_pkg`:**
  - `DATA_W=8`, `CNT_W=3`.
  - State enum: COLLECT, PARITY, WAIT.
- **Sub-module `demux_1to8_dec`:** combinational 3-to-8 one-hot write decoder with an active-low enable.
  - Inputs: select, `g_n`, and accept.
  - Output: drives the per-bit write enables of `sh`.

## Test plan
- **Reset then one frame:** reset, `g_n`=0, `LSB_FIRST`=1, stream bits 1,0,1,1,0,0,1,0 with `q_ready`=1 → `q`=8'h4D, `q_valid` high one cycle after the 8th accept, `bit_cnt` back to 0.
- **Backpressure:** `q_ready`=0, two frames 8'hA5 then 8'h3C → first frame held, `din_ready` drops after the 16th accept. Raise `q_ready` → 8'hA5 consumed, then 8'h3C presented with no gap.
- **Enable stall:** `g_n`=1 for 5 cycles after bit 3 → `bit_cnt` holds at 3 and `din_ready`=0. Resume → correct byte assembled.
- **Abort:** `clr` after 4 bits, then a full frame 8'hFF → `q`=8'hFF, no leftover bits. A `clr` coinciding with an accept discards that bit.
- **`LSB_FIRST`=0 instance:** same stream as the first test → `q`=8'hB2.
- **Parity build** (`DEMUX_DESER_PARITY_EN`): 8'h4D plus parity bit 0 → `parity_err`=0. Plus parity bit 1 → `parity_err`=1. Reset asserted mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/demux_8bit_deser_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared widths and the FSM state encoding for the demux_8bit_deser
//   deserializer and its write decoder.
//   DATA_W : width of the assembled parallel byte
//   CNT_W  : width of the bit sequence counter (demux select)
//   state_t: COLLECT (gathering bits), PARITY (awaiting parity bit, only used
//            when DEMUX_DESER_PARITY_EN is defined), WAIT (frame complete,
//            output register still occupied)
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        WAIT    = 2'd2
    } state_t;

endpackage : demux_pkg

// File: rtl/demux_8bit_deser_dec.sv
// -----------------------------------------------------------------------------
// demux_1to8_dec
//   Combinational 3-to-8 one-hot write decoder with active-low enable. Steers
//   an accepted serial bit to exactly one shadow-register position.
//   sel    : in  CNT_W   register position to write
//   g_n    : in  1       active-low enable; high forces all enables low
//   accept : in  1       a bit is being accepted this cycle
//   we     : out DATA_W  one-hot per-bit write enables (all zero when idle)
// -----------------------------------------------------------------------------
module demux_1to8_dec
    import demux_pkg::*;
(
    input  logic [CNT_W-1:0]  sel,
    input  logic              g_n,
    input  logic              accept,
    output logic [DATA_W-1:0] we
);

    // NOTE: assign a default to every always_comb output before any
    // conditional write; a missing default path infers a latch.
    always_comb begin
        we = '0;
        if (!g_n && accept) begin
            we[sel] = 1'b1;
        end
    end

endmodule : demux_1to8_dec

// File: rtl/demux_8bit_deser.sv
// -----------------------------------------------------------------------------
// demux_8bit_deser
//   Serial-in, 8-bit parallel-out deserializer. Each accepted bit is steered
//   by a 1-to-8 write decoder into a shadow register at the position chosen
//   by the sequence counter. A completed frame moves into a one-deep output
//   register with a valid/ready handshake; if that register is still full the
//   frame is parked in the shadow register (WAIT) until downstream drains it.
//
//   Optional feature macro: DEMUX_DESER_PARITY_EN
//     defined   -> a ninth (parity) bit follows each frame; even parity over
//                  data + parity bit is reported on parity_err with q.
//     undefined -> 8-bit frames, parity_err tied to 0.
//
//   Parameter LSB_FIRST: 1 = first bit lands in q[0], 0 = first bit in q[7].
//
//   Ports:
//     clk        in   1  clock, rising edge
//     rst        in   1  synchronous active-high reset
//     g_n        in   1  active-low input enable
//     clr        in   1  synchronous abort of the partial / waiting frame
//     din        in   1  serial data bit
//     din_valid  in   1  din valid this cycle
//     din_ready  out  1  block can accept a bit
//     q          out  8  assembled byte
//     q_valid    out  1  q holds an unconsumed frame
//     q_ready    in   1  downstream consumes q when q_valid is high
//     bit_cnt    out  3  index of the next bit to be written
//     parity_err out  1  1 = odd parity on the frame in q (qualified by q_valid)
// -----------------------------------------------------------------------------
module demux_8bit_deser
    import demux_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              g_n,
    input  logic              clr,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              q_ready,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic              parity_err
);

    state_t            state;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] we;
    logic [DATA_W-1:0] sh_next;
    logic [CNT_W-1:0]  idx;
    logic              accept;
    logic              slot_free;
    logic              last_bit;

    assign din_ready = ~g_n & (state != WAIT);
    assign accept    = din_valid & din_ready;
    assign slot_free = ~q_valid | q_ready;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign idx       = LSB_FIRST ? bit_cnt : (CNT_W'(DATA_W - 1) - bit_cnt);

    // Only data bits go through the decoder; the parity bit never touches sh.
    demux_1to8_dec u_dec (
        .sel    (idx),
        .g_n    (g_n),
        .accept (accept && (state == COLLECT)),
        .we     (we)
    );

    // Shadow register with the current bit merged in, so a frame can be
    // handed to q on the same edge its last bit is accepted.
    assign sh_next = (sh & ~we) | (we & {DATA_W{din}});

`ifdef DEMUX_DESER_PARITY_EN
    logic perr_q;     // parity result registered alongside q
    logic perr_pend;  // parity result of the frame parked in WAIT
    logic perr_calc;

    assign perr_calc  = (^sh) ^ din;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= COLLECT;
            sh      <= '0;
            bit_cnt <= '0;
            q       <= '0;
            q_valid <= 1'b0;
`ifdef DEMUX_DESER_PARITY_EN
            perr_q    <= 1'b0;
            perr_pend <= 1'b0;
`endif
        end else begin
            // NOTE: the consume-clear is written first; a load later in this
            // block assigns q_valid again and the last non-blocking write wins.
            if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end

            if (clr) begin
                state   <= COLLECT;
                sh      <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            sh      <= sh_next;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_bit) begin
`ifdef DEMUX_DESER_PARITY_EN
                                state <= PARITY;
`else
                                if (slot_free) begin
                                    q       <= sh_next;
                                    q_valid <= 1'b1;
                                end else begin
                                    state <= WAIT;
                                end
`endif
                            end
                        end
                    end

`ifdef DEMUX_DESER_PARITY_EN
                    PARITY: begin
                        if (accept) begin
                            if (slot_free) begin
                                q       <= sh;
                                perr_q  <= perr_calc;
                                q_valid <= 1'b1;
                                state   <= COLLECT;
                            end else begin
                                perr_pend <= perr_calc;
                                state     <= WAIT;
                            end
                        end
                    end
`endif

                    WAIT: begin
                        // Old frame drains and parked frame loads on one edge.
                        if (q_ready) begin
                            q       <= sh;
                            q_valid <= 1'b1;
                            state   <= COLLECT;
`ifdef DEMUX_DESER_PARITY_EN
                            perr_q  <= perr_pend;
`endif
                        end
                    end

                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule : demux_8bit_deser
